// File: rtl/gb_hdma_pkg.sv
// Shared definitions for the CGB HDMA/GDMA controller.
//   hdma_state_t : controller states (idle, general DMA, H-blank wait, H-blank block)
//   REG_HDMA1..5 : cpu_addr offsets for FF51..FF55
//   BLOCK_BYTES  : bytes moved per block
//   FF55_IDLE    : FF55 read value with no transfer pending
package gb_hdma_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GDMA,
        ST_HWAIT,
        ST_HBLOCK
    } hdma_state_t;

    localparam logic [2:0] REG_HDMA1 = 3'd1;
    localparam logic [2:0] REG_HDMA2 = 3'd2;
    localparam logic [2:0] REG_HDMA3 = 3'd3;
    localparam logic [2:0] REG_HDMA4 = 3'd4;
    localparam logic [2:0] REG_HDMA5 = 3'd5;

    localparam int unsigned BLOCK_BYTES = 16;
    localparam logic [7:0]  FF55_IDLE   = 8'hFF;

endpackage

// File: rtl/hdma_ctrl.sv
// CGB VRAM DMA controller (general-purpose and H-blank DMA).
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   cpu_sel/addr/wr/di  : CPU access to FF51..FF55 (addr 1..5)
//   cpu_do              : CPU read data (FF for FF51-FF54, status for FF55)
//   lcd_mode, lcd_on    : video mode (00 = H-blank) and LCD enable
//   cpu_stall           : CPU hold while a block is being copied
//   src_rd, src_addr    : source read strobe/address; src_data returns a clock later
//   vram_wr/addr/data   : VRAM write port
//   active              : a transfer (GDMA or HDMA) is pending or running
module hdma_ctrl
    import gb_hdma_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_sel,
    input  logic [2:0]  cpu_addr,
    input  logic        cpu_wr,
    input  logic [7:0]  cpu_di,
    output logic [7:0]  cpu_do,
    input  logic [1:0]  lcd_mode,
    input  logic        lcd_on,
    output logic        cpu_stall,
    output logic        src_rd,
    output logic [15:0] src_addr,
    input  logic [7:0]  src_data,
    output logic        vram_wr,
    output logic [12:0] vram_addr,
    output logic [7:0]  vram_data,
    output logic        active
);

    hdma_state_t state;

    // Only the bits that are not forced to zero are stored.
    logic [7:0]  src_hi;
    logic [3:0]  src_lo;
    logic [4:0]  dst_hi;
    logic [3:0]  dst_lo;

    logic [15:0] src_cnt;
    logic [12:0] dst_cnt;
    logic [6:0]  remaining;
    logic [3:0]  byte_cnt;
    logic        hblank_prev;

    logic cpu_write;
    logic wr55;
    logic hblank_now;
    logic hblank_edge;
    logic start_req;
    logic cancel_req;
    logic last_byte;

    assign cpu_write   = cpu_sel && cpu_wr;
    assign wr55        = cpu_write && (cpu_addr == REG_HDMA5);
    assign hblank_now  = (lcd_mode == 2'b00);
    assign hblank_edge = lcd_on && hblank_now && !hblank_prev;

    // A start is accepted from idle, or as an HDMA restart while waiting for H-blank;
    // bit7=0 while waiting is a cancel. Writes during a running block are dropped.
    assign start_req  = wr55 && ((state == ST_IDLE) || ((state == ST_HWAIT) && cpu_di[7]));
    assign cancel_req = wr55 && (state == ST_HWAIT) && !cpu_di[7];
    assign last_byte  = (byte_cnt == 4'(BLOCK_BYTES - 1));

    assign src_addr  = src_cnt;
    assign vram_addr = dst_cnt;
    assign vram_data = src_data;

    always_comb begin
        cpu_do = FF55_IDLE;
        if (cpu_sel && (cpu_addr == REG_HDMA5))
            cpu_do = {~active, remaining};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            src_hi      <= '0;
            src_lo      <= '0;
            dst_hi      <= '0;
            dst_lo      <= '0;
            src_cnt     <= '0;
            dst_cnt     <= '0;
            remaining   <= '1;
            byte_cnt    <= '0;
            hblank_prev <= 1'b0;
            cpu_stall   <= 1'b0;
            src_rd      <= 1'b0;
            vram_wr     <= 1'b0;
            active      <= 1'b0;
        end else begin
            hblank_prev <= hblank_now;

            // Address registers always follow the CPU; running counters are untouched.
            if (cpu_write) begin
                case (cpu_addr)
                    REG_HDMA1: src_hi <= cpu_di;
                    REG_HDMA2: src_lo <= cpu_di[7:4];
                    REG_HDMA3: dst_hi <= cpu_di[4:0];
                    REG_HDMA4: dst_lo <= cpu_di[7:4];
                    default:   ;
                endcase
            end

            if (start_req) begin
                src_cnt   <= {src_hi, src_lo, 4'h0};
                dst_cnt   <= {dst_hi, dst_lo, 4'h0};
                remaining <= cpu_di[6:0];
                byte_cnt  <= '0;
                active    <= 1'b1;
                // GDMA, or HDMA with the LCD off, begins copying on the next clock.
                if (!cpu_di[7] || !lcd_on) begin
                    state     <= cpu_di[7] ? ST_HBLOCK : ST_GDMA;
                    cpu_stall <= 1'b1;
                    src_rd    <= 1'b1;
                end else begin
                    state     <= ST_HWAIT;
                end
            end else if (cancel_req) begin
                state  <= ST_IDLE;
                active <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: ;

                    ST_HWAIT: begin
                        if (hblank_edge) begin
                            state     <= ST_HBLOCK;
                            cpu_stall <= 1'b1;
                            src_rd    <= 1'b1;
                        end
                    end

                    ST_GDMA, ST_HBLOCK: begin
                        // src_rd and vram_wr alternate: read cycle, then write cycle.
                        if (src_rd) begin
                            src_rd  <= 1'b0;
                            vram_wr <= 1'b1;
                        end else if (vram_wr) begin
                            vram_wr  <= 1'b0;
                            src_cnt  <= src_cnt + 16'd1;
                            dst_cnt  <= dst_cnt + 13'd1;
                            byte_cnt <= byte_cnt + 4'd1;
                            if (last_byte) begin
                                // Decrementing from 0 wraps to 7F, giving FF55=FF when done.
                                remaining <= remaining - 7'd1;
                                if (remaining == 7'd0) begin
                                    state     <= ST_IDLE;
                                    cpu_stall <= 1'b0;
                                    active    <= 1'b0;
                                end else if (state == ST_HBLOCK) begin
                                    state     <= ST_HWAIT;
                                    cpu_stall <= 1'b0;
                                end else begin
                                    src_rd <= 1'b1;
                                end
                            end else begin
                                src_rd <= 1'b1;
                            end
                        end
                    end

                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hdma_ctrl.sv
// Directed bench for hdma_ctrl: expected VRAM writes are queued when a transfer
// is started and retired by a monitor on each observed write.
module tb_hdma_ctrl;

    logic        clk;
    logic        reset;
    logic        cpu_sel;
    logic [2:0]  cpu_addr;
    logic        cpu_wr;
    logic [7:0]  cpu_di;
    logic [7:0]  cpu_do;
    logic [1:0]  lcd_mode;
    logic        lcd_on;
    logic        cpu_stall;
    logic        src_rd;
    logic [15:0] src_addr;
    logic [7:0]  src_data;
    logic        vram_wr;
    logic [12:0] vram_addr;
    logic [7:0]  vram_data;
    logic        active;

    int checks    = 0;
    int failures  = 0;
    int stall_cnt = 0;

    logic [20:0] sb[$];

    hdma_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_sel   (cpu_sel),
        .cpu_addr  (cpu_addr),
        .cpu_wr    (cpu_wr),
        .cpu_di    (cpu_di),
        .cpu_do    (cpu_do),
        .lcd_mode  (lcd_mode),
        .lcd_on    (lcd_on),
        .cpu_stall (cpu_stall),
        .src_rd    (src_rd),
        .src_addr  (src_addr),
        .src_data  (src_data),
        .vram_wr   (vram_wr),
        .vram_addr (vram_addr),
        .vram_data (vram_data),
        .active    (active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] src_fn(input logic [15:0] a);
        return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h5A;
    endfunction

    // Source memory: data returned the clock after the read strobe.
    initial src_data = 8'h00;
    always @(posedge clk) if (src_rd === 1'b1) src_data <= src_fn(src_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (vram_wr === 1'b1) begin
            chk("vram_wr_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                logic [20:0] e;
                e = sb.pop_front();
                chk("vram_addr", 32'(vram_addr), 32'(e[20:8]));
                chk("vram_data", 32'(vram_data), 32'(e[7:0]));
            end
        end
        if (cpu_stall === 1'b1) stall_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        cpu_sel  = 1'b1;
        cpu_wr   = 1'b1;
        cpu_addr = a;
        cpu_di   = d;
        tick(1);
        cpu_sel  = 1'b0;
        cpu_wr   = 1'b0;
        cpu_addr = 3'd0;
    endtask

    task automatic rd(input string tag, input logic [2:0] a, input logic [7:0] exp);
        cpu_sel  = 1'b1;
        cpu_addr = a;
        #1;
        chk(tag, 32'(cpu_do), 32'(exp));
        cpu_sel  = 1'b0;
        cpu_addr = 3'd0;
    endtask

    task automatic push_xfer(input logic [15:0] src, input logic [12:0] dst, input int n);
        for (int i = 0; i < n; i++) begin
            logic [15:0] a;
            logic [12:0] d;
            a = src + 16'(i);
            d = dst + 13'(i);
            sb.push_back({d, src_fn(a)});
        end
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while (active !== 1'b0 && n < budget) begin
            tick(1);
            n++;
        end
        chk(tag, 32'(active), 32'd0);
    endtask

    task automatic set_regs(input logic [7:0] r1, input logic [7:0] r2,
                            input logic [7:0] r3, input logic [7:0] r4);
        wr(3'd1, r1);
        wr(3'd2, r2);
        wr(3'd3, r3);
        wr(3'd4, r4);
    endtask

    initial begin
        reset    = 1'b1;
        cpu_sel  = 1'b0;
        cpu_wr   = 1'b0;
        cpu_addr = 3'd0;
        cpu_di   = 8'h00;
        lcd_mode = 2'b11;
        lcd_on   = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(1);

        // Reset state
        chk("rst_stall", 32'(cpu_stall), 32'd0);
        chk("rst_src_rd", 32'(src_rd), 32'd0);
        chk("rst_vram_wr", 32'(vram_wr), 32'd0);
        chk("rst_active", 32'(active), 32'd0);
        rd("rst_ff55", 3'd5, 8'hFF);
        rd("rst_ff51", 3'd1, 8'hFF);

        // GDMA C000 -> 0000, 32 bytes; low nibbles / high dst bits forced to 0
        set_regs(8'hC0, 8'h0F, 8'h80, 8'h05);
        rd("ff54_read", 3'd4, 8'hFF);
        push_xfer(16'hC000, 13'h0000, 32);
        stall_cnt = 0;
        wr(3'd5, 8'h01);
        chk("gdma_stall_rise", 32'(cpu_stall), 32'd1);
        chk("gdma_first_rd", 32'(src_rd), 32'd1);
        chk("gdma_src_addr", 32'(src_addr), 32'hC000);
        rd("gdma_ff55_busy", 3'd5, 8'h01);
        tick(8);
        wr(3'd1, 8'h12);        // register-only update while running
        wr(3'd5, 8'h00);        // ignored during GDMA
        wait_idle("gdma_done", 200);
        chk("gdma_stall_cycles", 32'(stall_cnt), 32'd64);
        chk("gdma_sb_empty", 32'(sb.size()), 32'd0);
        rd("gdma_ff55_end", 3'd5, 8'hFF);

        // HDMA, three blocks, D120 -> 0140
        set_regs(8'hD1, 8'h20, 8'h01, 8'h40);
        push_xfer(16'hD120, 13'h0140, 48);
        wr(3'd5, 8'h82);
        tick(3);
        chk("hdma_wait_stall", 32'(cpu_stall), 32'd0);
        rd("hdma_ff55_wait", 3'd5, 8'h02);
        stall_cnt = 0;
        lcd_mode = 2'b00;
        tick(1);
        chk("hdma_b1_stall_rise", 32'(cpu_stall), 32'd1);
        tick(59);
        chk("hdma_b1_stall_cycles", 32'(stall_cnt), 32'd32);
        rd("hdma_ff55_b1", 3'd5, 8'h01);
        lcd_mode = 2'b11;
        tick(2);
        stall_cnt = 0;
        lcd_mode = 2'b00;
        tick(5);
        lcd_mode = 2'b11;       // second H-blank edge inside the block: ignored
        tick(1);
        lcd_mode = 2'b00;
        tick(55);
        chk("hdma_b2_stall_cycles", 32'(stall_cnt), 32'd32);
        rd("hdma_ff55_b2", 3'd5, 8'h00);
        lcd_mode = 2'b11;
        tick(2);
        stall_cnt = 0;
        lcd_mode = 2'b00;
        tick(60);
        chk("hdma_b3_stall_cycles", 32'(stall_cnt), 32'd32);
        chk("hdma_active_end", 32'(active), 32'd0);
        rd("hdma_ff55_end", 3'd5, 8'hFF);
        chk("hdma_sb_empty", 32'(sb.size()), 32'd0);

        // Cancel after one block
        lcd_mode = 2'b11;
        set_regs(8'hA0, 8'h00, 8'h02, 8'h00);
        push_xfer(16'hA000, 13'h0200, 16);
        wr(3'd5, 8'h85);
        tick(2);
        lcd_mode = 2'b00;
        tick(40);
        rd("cancel_ff55_mid", 3'd5, 8'h04);
        wr(3'd5, 8'h00);
        chk("cancel_active", 32'(active), 32'd0);
        rd("cancel_ff55", 3'd5, 8'h84);
        lcd_mode = 2'b11;
        tick(2);
        stall_cnt = 0;
        lcd_mode = 2'b00;
        tick(40);
        chk("cancel_no_stall", 32'(stall_cnt), 32'd0);
        chk("cancel_sb_empty", 32'(sb.size()), 32'd0);

        // Wrap: src FFF0 and dst 1FF0, two blocks
        lcd_mode = 2'b11;
        set_regs(8'hFF, 8'hF0, 8'h1F, 8'hF0);
        push_xfer(16'hFFF0, 13'h1FF0, 32);
        stall_cnt = 0;
        wr(3'd5, 8'h01);
        wait_idle("wrap_done", 200);
        chk("wrap_stall_cycles", 32'(stall_cnt), 32'd64);
        chk("wrap_sb_empty", 32'(sb.size()), 32'd0);
        rd("wrap_ff55", 3'd5, 8'hFF);

        // HDMA with LCD off: first block runs at once
        lcd_on = 1'b0;
        set_regs(8'h40, 8'h00, 8'h03, 8'h00);
        push_xfer(16'h4000, 13'h0300, 16);
        stall_cnt = 0;
        wr(3'd5, 8'h80);
        chk("lcdoff_stall_rise", 32'(cpu_stall), 32'd1);
        wait_idle("lcdoff_done", 100);
        chk("lcdoff_stall_cycles", 32'(stall_cnt), 32'd32);
        chk("lcdoff_sb_empty", 32'(sb.size()), 32'd0);
        rd("lcdoff_ff55", 3'd5, 8'hFF);
        lcd_on = 1'b1;

        // Reset during the fifth byte of a GDMA
        set_regs(8'hC0, 8'h00, 8'h00, 8'h00);
        push_xfer(16'hC000, 13'h0000, 5);
        wr(3'd5, 8'h03);
        tick(9);
        chk("rstmid_in_write", 32'(vram_wr), 32'd1);
        reset = 1'b1;
        tick(1);
        chk("rstmid_src_rd", 32'(src_rd), 32'd0);
        chk("rstmid_vram_wr", 32'(vram_wr), 32'd0);
        chk("rstmid_stall", 32'(cpu_stall), 32'd0);
        chk("rstmid_active", 32'(active), 32'd0);
        rd("rstmid_ff55", 3'd5, 8'hFF);
        reset = 1'b0;
        tick(6);
        chk("rstmid_idle", 32'(active), 32'd0);
        chk("rstmid_sb_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hdma_ctrl.md
HDMA_CTRL -- requirements
Module: hdma_ctrl

Interface
REQ-001 clk  in  1  system clock; all state on rising edge.
REQ-002 reset  in  1  synchronous, active-high.
REQ-003 cpu_sel  in  1  CPU address in FF51-FF55.
REQ-004 cpu_addr  in  3  register offset: 1..5 map to FF51..FF55.
REQ-005 cpu_wr  in  1  CPU write strobe, qualified by cpu_sel.
REQ-006 cpu_di  in  8  CPU write data.
REQ-007 cpu_do  out  8  CPU read data for the selected register.
REQ-008 lcd_mode  in  2  video mode; 2'b00 means H-blank.
REQ-009 lcd_on  in  1  LCD enabled.
REQ-010 cpu_stall  out  1  holds the CPU while a transfer owns the bus.
REQ-011 src_rd  out  1  source read strobe.
REQ-012 src_addr  out  16  source byte address.
REQ-013 src_data  in  8  source data, valid one clock after src_rd.
REQ-014 vram_wr  out  1  VRAM write strobe.
REQ-015 vram_addr  out  13  VRAM byte address.
REQ-016 vram_data  out  8  VRAM write data.
REQ-017 active  out  1  a GDMA or HDMA transfer is in progress.

Function
REQ-018 FF51/FF52 SHALL hold the source address; bits 3:0 of FF52 are forced to 0.
- FF53/FF54 SHALL hold the destination address; bits 7:5 of FF53 and bits 3:0 of FF54 are forced to 0.
REQ-019 Reads of FF51-FF54 SHALL return 8'hFF.
REQ-020 A read of FF55 SHALL return {~active, remaining_blocks[6:0]}; it is 8'hFF after completion and after reset.
REQ-021 A write to FF55 with bit7=0 while idle SHALL start a GDMA of (cpu_di[6:0]+1)*16 bytes.
- The same write loads the source counter from FF51/52 and the destination counter from FF53/54.
REQ-022 A write to FF55 with bit7=1 SHALL start an HDMA with the same counter loads.
REQ-023 A write to FF55 with bit7=0 while an HDMA is active SHALL cancel it at the next block boundary.
- After the cancel, FF55 reads {1'b1, remaining_blocks}.
REQ-024 States SHALL be IDLE, GDMA, HWAIT and HBLOCK.
- IDLE→GDMA on a GDMA start.
- IDLE→HWAIT on an HDMA start.
- HWAIT→HBLOCK on the rising edge of (lcd_mode==00) while lcd_on=1.
- HBLOCK→HWAIT after 16 bytes when blocks remain.
- GDMA and HBLOCK→IDLE when the last block completes.
REQ-025 An HDMA start with lcd_on=0 SHALL enter HBLOCK immediately for the first block.
REQ-026 Each byte SHALL take 2 clocks.
- Clock 1: read cycle, src_rd=1, src_addr=source counter.
- Clock 2: write cycle, vram_wr=1, vram_addr=destination counter, vram_data=src_data; both counters increment.
- A 16-byte block therefore takes exactly 32 clocks.
REQ-027 The source counter SHALL wrap FFFF→0000; the destination counter SHALL wrap 1FFF→0000.
REQ-028 remaining_blocks SHALL decrement at the end of each block; the transfer ends when it decrements from 0.
REQ-029 cpu_stall SHALL be high in GDMA and HBLOCK and low otherwise.
- It rises in the clock after the FF55 write or H-blank edge and falls in the clock after the final write cycle.
REQ-030 Writes to FF51-FF54 during a transfer SHALL update only the registers, never the running counters.
REQ-031 A write to FF55 with bit7=1 during HWAIT SHALL restart the HDMA with reloaded counters and length.
REQ-032 A write to FF55 during GDMA or HBLOCK SHALL be ignored.
REQ-033 An H-blank edge arriving during HBLOCK SHALL be ignored; no queued block.
REQ-034 The H-blank edge detector SHALL sample lcd_mode from the previous clock.
- A sustained mode 00 yields exactly one block per H-blank.

Reset
REQ-035 Reset SHALL force state IDLE and clear FF51-FF54 and both counters to 0.
- remaining_blocks SHALL be 7'h7F.
- cpu_stall, src_rd, vram_wr and active SHALL be 0; cpu_do SHALL read 8'hFF at FF55.
REQ-036 Reset mid-transfer SHALL abort at once with no further src_rd or vram_wr.

Structure
REQ-037 Shared package gb_hdma_pkg SHALL define the state enum, register offsets 1..5, BLOCK_BYTES=16 and the FF55 idle value 8'hFF.
REQ-038 No sub-module; the H-blank edge detector is inline.

Verification
REQ-039 GDMA: FF51=C0, FF52=00, FF53=80, FF54=00, FF55=01 → 32 bytes from C000..C01F to VRAM 0000..001F; cpu_stall high for exactly 64 clocks; FF55 reads FF.
REQ-040 HDMA: FF55=82, lcd_on=1, three H-blank edges → three 32-clock bursts; FF55 reads 01, then 00, then FF.
REQ-041 Cancel: HDMA with FF55=85, one block done, write FF55=00 in HWAIT → no further transfer; FF55 reads 84.
REQ-042 Wrap: FF53=1F, FF54=F0, GDMA length 2 → writes go to VRAM 1FF0..1FFF then 0000..000F.
REQ-043 LCD off: FF55=80 with lcd_on=0 → one block immediately, active drops, FF55 reads FF.
REQ-044 Reset asserted at byte 5 of a GDMA → next clock src_rd=0, vram_wr=0, cpu_stall=0; FF55 reads FF.
